// File: rtl/logic_gate_pipe.sv
// Registered bitwise gate with sticky OR-accumulate, valid/ready output
// stage, reduction flags and a saturating accepted-transaction counter.
module logic_gate_pipe #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [2:0]       op,
   input  logic             acc_en,
   input  logic             acc_clr,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_any,
   output logic             out_all,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] acc_q,
   output logic [CNT_W-1:0] xfer_cnt
);

   logic [WIDTH-1:0] res;
   logic [WIDTH-1:0] val;
   logic             accept;

   logic [WIDTH-1:0] data_q, data_d;
   logic             any_q, any_d;
   logic             all_q, all_d;
   logic             valid_q, valid_d;
   logic [WIDTH-1:0] acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign in_ready = !valid_q || out_ready;
   assign accept   = in_valid && in_ready;

   always_comb begin
      res = '0;
      unique case (op)
         3'b000: res = in_a & in_b;
         3'b001: res = in_a | in_b;
         3'b010: res = in_a ^ in_b;
         3'b011: res = ~(in_a & in_b);
         3'b100: res = ~(in_a | in_b);
         3'b101: res = ~(in_a ^ in_b);
         3'b110: res = in_a;
         3'b111: res = ~in_a;
      endcase
   end

   always_comb begin
      val     = res;
      data_d  = data_q;
      any_d   = any_q;
      all_d   = all_q;
      valid_d = valid_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      if (accept) begin
         // acc_clr with acc_en restarts the accumulator from this result
         if (acc_en) begin
            val   = acc_clr ? res : (acc_q | res);
            acc_d = val;
         end else if (acc_clr) begin
            acc_d = '0;
         end
         data_d  = val;
         any_d   = |val;
         all_d   = &val;
         valid_d = 1'b1;
         if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end else if (out_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q  <= '0;
         any_q   <= 1'b0;
         all_q   <= 1'b0;
         valid_q <= 1'b0;
         acc_q   <= '0;
         cnt_q   <= '0;
      end else begin
         data_q  <= data_d;
         any_q   <= any_d;
         all_q   <= all_d;
         valid_q <= valid_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
      end
   end

   assign out_data  = data_q;
   assign out_any   = any_q;
   assign out_all   = all_q;
   assign out_valid = valid_q;
   assign xfer_cnt  = cnt_q;

endmodule

// File: doc/logic_gate_pipe.md
Name: logic_gate_pipe

Overview:
- Parametrised, registered successor to the 2-input OR gate.
- Applies a runtime-selected bitwise gate (AND/OR/XOR/NAND/NOR/XNOR/PASS/NOT) to two WIDTH-bit operands.
- Optional sticky OR-accumulate mode; registers the result behind a valid/ready handshake with reduction flags and a saturating transaction counter.
- Basic building block for flag collection and masking datapaths in the logic-gate library.

Parameters:
- WIDTH, 8, operand/result width in bits (>=1)
- CNT_W, 8, width of the accepted-transaction counter (>=1)

Ports:
- clk, input, 1, rising-edge clock
- rst, input, 1, asynchronous active-high reset
- in_a, input, WIDTH, operand A
- in_b, input, WIDTH, operand B
- op, input, 3, gate select, sampled with the transaction
- acc_en, input, 1, accumulate mode for this transaction
- acc_clr, input, 1, restart accumulator with this transaction
- in_valid, input, 1, upstream transaction present
- in_ready, output, 1, block can accept this cycle
- out_data, output, WIDTH, registered result
- out_any, output, 1, OR-reduction of out_data
- out_all, output, 1, AND-reduction of out_data
- out_valid, output, 1, out_data/out_any/out_all valid
- out_ready, input, 1, downstream accepts
- acc_q, output, WIDTH, current accumulator contents
- xfer_cnt, output, CNT_W, count of accepted input transactions, saturating

Behaviour:
- Reset (async assert, sync release at clk): out_data=0, out_any=0, out_all=0, out_valid=0, acc_q=0, xfer_cnt=0. in_ready=1 after reset.
- Reset mid-operation discards any held output and clears the accumulator; no partial result survives.
- op encoding:
  - 000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR.
  - 110 PASS A (res=in_a), 111 NOT A (res=~in_a); in_b ignored for 110/111.
  - All ops are purely bitwise per lane; no carries.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Accept = in_valid && in_ready.
  - Output accepted when out_valid && out_ready.
- Latency: exactly 1 cycle. On accept at edge N, out_valid=1 with the result from edge N.
- Back-to-back: full throughput (one transaction per cycle) while out_ready=1.
- Stall: while out_valid=1 and out_ready=0, out_data/out_any/out_all/out_valid are held stable and in_ready=0.
- On accept:
  - acc_en=0: out_data<=res; acc_q unchanged.
  - acc_en=1, acc_clr=0: out_data<=acc_q|res; acc_q<=acc_q|res.
  - acc_en=1, acc_clr=1: out_data<=res; acc_q<=res (clear and load in the same cycle).
  - acc_en=0, acc_clr=1: out_data<=res; acc_q<=0.
- out_any/out_all are computed from the value being registered into out_data and are registered alongside it (same cycle).
- No accept and output consumed: out_valid<=0; out_data holds its last value.
- acc_en/acc_clr are ignored when no accept occurs; acc_q never changes without an accept.
- xfer_cnt increments by 1 per accept and saturates at 2^CNT_W-1 (no wrap). Only rst clears it.
- The same-cycle accept of a new input and consume of the held output is legal: the new result replaces the old one with out_valid kept at 1.

Test Plan:
1. Reset, WIDTH=8: pulse rst mid-stream while out_valid=1 -> all outputs 0 immediately (async), in_ready=1, xfer_cnt=0.
2. Op sweep, out_ready=1: in_a=8'hCA, in_b=8'h5C, op 000..111 -> out_data one cycle later = 48, DE, 96, B7, 21, 69, CA, 35 respectively; out_any=1 for all, out_all=0 for all.
3. Reduction flags: op=001, in_a=8'hF0, in_b=8'h0F -> out_data=FF, out_all=1, out_any=1. op=000 on the same operands -> out_data=00, out_any=0, out_all=0.
4. Accumulate: acc_en=1 with acc_clr=1 on the first beat; op=110 with in_a=01, 04, 80 on consecutive cycles -> out_data=01, 05, 85; acc_q=85. Next beat acc_clr=1, in_a=02 -> out_data=02, acc_q=02.
5. Backpressure: out_ready=0 after the first result (in_a=8'h11, op=110) with in_valid held high and in_a=8'h22 -> in_ready=0, out_data stays 11 for 5 cycles, xfer_cnt stays 1. Raise out_ready -> 11 consumed, 22 appears next cycle, xfer_cnt=2.
6. Counter saturation, CNT_W=3: 10 back-to-back accepts -> xfer_cnt reads 1..7 then stays at 7.
